// File: rtl/bit_population_generator.sv
// Emits every WIDTH-bit word with popcount N in ascending order, one word per
// accepted valid/ready transfer.
module bit_population_generator #(
  parameter int WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic [$clog2(WIDTH):0]  cnt_i,
  input  logic                    cnt_val_i,
  output logic                    cnt_rdy_o,
  output logic [WIDTH-1:0]        data_o,
  output logic                    data_val_o,
  input  logic                    data_rdy_i,
  output logic                    data_last_o,
  output logic                    err_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] N_MAX = CW'(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  function automatic logic [IW-1:0] ctz(input logic [WIDTH-1:0] v);
    ctz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) ctz = IW'(i);
    end
  endfunction

  function automatic logic [WIDTH-1:0] low_ones(input logic [CW-1:0] n);
    low_ones = ~({WIDTH{1'b1}} << n);
  endfunction

  // Snoob step: next larger word with the same popcount.
  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] c, r;
    c = x & (~x + WIDTH'(1));
    r = x + c;
    next_word = r | (((r ^ x) >> 2) >> ctz(c));
  endfunction

  // Final patterns (top N bits set, including zero) are exactly the words
  // whose clear bits all sit below the lowest set bit.
  function automatic logic is_final(input logic [WIDTH-1:0] x);
    is_final = &(x | (x - WIDTH'(1)));
  endfunction

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] first;

  assign nxt   = next_word(data_q);
  assign first = low_ones(cnt_i);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_val_i) begin
          if (cnt_i > N_MAX) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            data_d  = first;
            last_d  = is_final(first);
          end
        end
      end
      RUN: begin
        if (data_rdy_i) begin
          if (last_q) begin
            state_d = IDLE;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            data_d = nxt;
            last_d = is_final(nxt);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign cnt_rdy_o   = (state_q == IDLE);
  assign data_val_o  = (state_q == RUN);
  assign data_o      = data_q;
  assign data_last_o = last_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_bit_population_generator.sv
// Scoreboard bench: directed requests push expected words; monitors pop and
// compare on every transfer. Second instance covers the wide N=8 sweep.
module tb_bit_population_generator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic [2:0] cnt4 = '0;
  logic       cval4 = 1'b0, crdy4, val4, rdy4 = 1'b1, last4, err4;
  logic [3:0] data4;

  // WIDTH=16 instance
  logic [4:0]  cnt16 = '0;
  logic        cval16 = 1'b0, crdy16, val16, rdy16 = 1'b1, last16, err16;
  logic [15:0] data16;

  bit_population_generator #(.WIDTH(4)) u4 (
    .clk_i(clk), .srst_i(rst), .cnt_i(cnt4), .cnt_val_i(cval4),
    .cnt_rdy_o(crdy4), .data_o(data4), .data_val_o(val4),
    .data_rdy_i(rdy4), .data_last_o(last4), .err_o(err4)
  );

  bit_population_generator #(.WIDTH(16)) u16 (
    .clk_i(clk), .srst_i(rst), .cnt_i(cnt16), .cnt_val_i(cval16),
    .cnt_rdy_o(crdy16), .data_o(data16), .data_val_o(val16),
    .data_rdy_i(rdy16), .data_last_o(last16), .err_o(err16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } exp_t;
  exp_t exp4[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp4.push_back(e);
  endtask

  // W4 monitor: pop on transfer, and hold-stable check while stalled.
  logic       stall_p = 1'b0;
  logic [3:0] held_d;
  logic       held_l;
  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("stall_data", data4, held_d);
        chk("stall_last", last4, held_l);
        chk("stall_val", val4, 1);
      end
      if (val4 && rdy4) begin
        if (exp4.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h, required none", data4);
        end else begin
          exp_t e;
          e = exp4.pop_front();
          chk("word", data4, e.data);
          chk("word_last", last4, e.last);
        end
      end
      chk("err_vs_val", err4 && val4, 0);
      stall_p = val4 && !rdy4;
      held_d  = data4;
      held_l  = last4;
    end
  end

  // W16 monitor: popcount, strict ascent, endpoints, count.
  int          cnt_w16 = 0;
  logic [15:0] prev16 = '0;
  always @(negedge clk) begin
    if (!rst && val16 && rdy16) begin
      chk("w16_popcount", $countones(data16), 8);
      if (cnt_w16 == 0) chk("w16_first", data16, 16'h00FF);
      else              chk("w16_ascending", data16 > prev16, 1);
      chk("w16_last_flag", last16, data16 == 16'hFF00);
      prev16 = data16;
      cnt_w16++;
    end
  end

  task automatic request4(input logic [2:0] n);
    @(posedge clk); #1;
    cnt4  = n;
    cval4 = 1'b1;
    @(posedge clk); #1;
    cval4 = 1'b0;
  endtask

  task automatic wait_idle4(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (crdy4 && exp4.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("idle_reached", (crdy4 && exp4.size() == 0), 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_cnt_rdy", crdy4, 1);
    chk("rst_val", val4, 0);
    chk("rst_data", data4, 0);
    chk("rst_last", last4, 0);
    chk("rst_err", err4, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // N=2, full speed
    push(4'h3, 0); push(4'h5, 0); push(4'h6, 0);
    push(4'h9, 0); push(4'hA, 0); push(4'hC, 1);
    request4(3'd2);
    chk("n2_first_val", val4, 1);
    chk("n2_first_data", data4, 4'h3);
    chk("n2_busy", crdy4, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("n2_last_data", data4, 4'hC);
    chk("n2_last_flag", last4, 1);
    chk("n2_still_busy", crdy4, 0);
    @(posedge clk); #1;
    chk("n2_rdy_after", crdy4, 1);
    chk("n2_val_after", val4, 0);
    wait_idle4(20);

    // N=0 then N=4
    push(4'h0, 1);
    request4(3'd0);
    chk("n0_val", val4, 1);
    chk("n0_data", data4, 4'h0);
    chk("n0_last", last4, 1);
    wait_idle4(20);
    push(4'hF, 1);
    request4(3'd4);
    chk("n4_val", val4, 1);
    chk("n4_data", data4, 4'hF);
    chk("n4_last", last4, 1);
    wait_idle4(20);

    // N=5 rejected
    request4(3'd5);
    chk("n5_err", err4, 1);
    chk("n5_val", val4, 0);
    chk("n5_rdy", crdy4, 1);
    @(posedge clk); #1;
    chk("n5_err_clear", err4, 0);
    chk("n5_val2", val4, 0);
    chk("n5_rdy2", crdy4, 1);

    // N=2 with random stalls
    push(4'h3, 0); push(4'h5, 0); push(4'h6, 0);
    push(4'h9, 0); push(4'hA, 0); push(4'hC, 1);
    request4(3'd2);
    for (int i = 0; i < 200 && exp4.size() != 0; i++) begin
      rdy4 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rdy4 = 1'b1;
    wait_idle4(20);

    // Async reset mid-sequence after the 3rd word
    push(4'h3, 0); push(4'h5, 0); push(4'h6, 0);
    request4(3'd2);
    repeat (3) @(posedge clk);
    #2;
    exp4.delete();
    rst = 1'b1;
    #1;
    chk("arst_val", val4, 0);
    chk("arst_data", data4, 0);
    chk("arst_rdy", crdy4, 1);
    #1 rst = 1'b0;
    push(4'h1, 0); push(4'h2, 0); push(4'h4, 0); push(4'h8, 1);
    request4(3'd1);
    chk("n1_first", data4, 4'h1);
    wait_idle4(20);

    // WIDTH=16, N=8 sweep
    @(posedge clk); #1;
    cnt16  = 5'd8;
    cval16 = 1'b1;
    @(posedge clk); #1;
    cval16 = 1'b0;
    for (int i = 0; i < 14000 && !crdy16; i++) begin
      @(posedge clk); #1;
    end
    chk("w16_done", crdy16, 1);
    chk("w16_count", cnt_w16, 12870);
    chk("w16_final_prev", prev16, 16'hFF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
